// File: rtl/alu_arb_pkg.sv
// Shared constants for the round-robin ALU arbiter: op codes, widths and
// the requester-id width helper.
package alu_arb_pkg;
  localparam int ALU_OP_W    = 4;
  localparam int XLEN        = 32;
  localparam int ALU_OP_LAST = 11;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_EQ    = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd11;

  // Width of a requester index; never below one bit.
  function automatic int arb_id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/alu_core.sv
// Team ALU: pure combinational 32-bit datapath, no flags. Illegal op codes
// produce zero; callers decide how to flag them.
module alu_core
  import alu_arb_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output logic [XLEN-1:0]     y_o
);
  logic [4:0] sh;

  always_comb begin
    sh  = b_i[4:0];
    y_o = '0;
    case (op_i)
      ALU_ADD:   y_o = a_i + b_i;
      ALU_SUB:   y_o = a_i - b_i;
      ALU_SLL:   y_o = a_i << sh;
      ALU_SLT:   y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU:  y_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:   y_o = a_i ^ b_i;
      ALU_SRL:   y_o = a_i >> sh;
      ALU_SRA:   y_o = $unsigned($signed(a_i) >>> sh);
      ALU_OR:    y_o = a_i | b_i;
      ALU_AND:   y_o = a_i & b_i;
      ALU_EQ:    y_o = {{(XLEN-1){1'b0}}, (a_i == b_i)};
      ALU_PASSB: y_o = b_i;
      default:   y_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above the
// priority pointer, wrapping modulo NREQ.
module alu_rr_pick #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);
  int c;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    c       = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr_i) + k) % NREQ;
      if (!any_o && valid_i[c]) begin
        any_o      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = ID_W'(c);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU stage between NREQ requesters.
// Optional per-requester accept counters are enabled with ALU_ARB_PERF_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [ALU_OP_W*NREQ-1:0] req_op,
  input  logic [XLEN*NREQ-1:0]     req_a,
  input  logic [XLEN*NREQ-1:0]     req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_id,
  output logic [XLEN-1:0]          rsp_result,
  output logic                     rsp_err
`ifdef ALU_ARB_PERF_EN
  ,
  input  logic                     perf_clr,
  output logic [16*NREQ-1:0]       perf_cnt
`endif
);
  localparam int ID_W = arb_id_w(NREQ);

  logic [ID_W-1:0]     ptr_q, ptr_d, win_idx;
  logic [NREQ-1:0]     grant;
  logic                any_vld, can_issue, accept;
  logic                valid_q, valid_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic [1:0]          id_q, id_d;
  logic [XLEN-1:0]     alu_y;
  logic                op_illegal;

  alu_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (any_vld)
  );

  always_comb begin
    can_issue = !valid_q || rsp_ready;
    accept    = can_issue && any_vld;
    req_ready = can_issue ? grant : '0;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    if (accept) begin
      valid_d = 1'b1;
      op_d    = req_op[int'(win_idx)*ALU_OP_W +: ALU_OP_W];
      a_d     = req_a[int'(win_idx)*XLEN +: XLEN];
      b_d     = req_b[int'(win_idx)*XLEN +: XLEN];
      id_d    = 2'(win_idx);
      ptr_d   = (win_idx == ID_W'(NREQ-1)) ? '0 : win_idx + ID_W'(1);
    end else if (rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
    end
  end

  // Stage register -> ALU -> response; illegal ops are masked to zero here.
  alu_core u_alu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (alu_y)
  );

  assign op_illegal = (op_q > ALU_OP_W'(ALU_OP_LAST));
  assign rsp_valid  = valid_q;
  assign rsp_id     = id_q;
  assign rsp_err    = op_illegal;
  assign rsp_result = op_illegal ? '0 : alu_y;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] cnt_q [NREQ];
  logic [15:0] cnt_d [NREQ];

  // Clear takes priority over a coincident accept.
  always_comb begin
    perf_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (perf_clr)
        cnt_d[i] = '0;
      else if (accept && grant[i])
        cnt_d[i] = cnt_q[i] + 16'd1;
      perf_cnt[16*i +: 16] = cnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic scored
// against a transaction-level model of the arbiter.
module tb_alu_arbiter;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_op;
  logic [32*NREQ-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_result;
  logic              rsp_err;
`ifdef ALU_ARB_PERF_EN
  logic              perf_clr;
  logic [16*NREQ-1:0] perf_cnt;
`endif

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_clr   (perf_clr),
    .perf_cnt   (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side state: a pending op is held until accepted.
  bit          pv [NREQ];
  logic [3:0]  pop [NREQ];
  logic [31:0] pa [NREQ], pb [NREQ];

  // Transaction-level model of the response slot and priority pointer.
  int          m_ptr;
  bit          m_valid;
  int          m_id;
  logic [31:0] m_res;
  bit          m_err;
  logic [15:0] m_cnt [NREQ];
  logic [NREQ-1:0] obs_ready;

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic signed [31:0] sa;
    sh = int'(b[4:0]);
    sa = a;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << sh;
      3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> sh;
      7:  return sa >>> sh;
      8:  return a | b;
      9:  return a & b;
      10: return (a == b) ? 32'd1 : 32'd0;
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_id = 0; m_res = 0; m_err = 0;
    for (int i = 0; i < NREQ; i++) begin
      m_cnt[i] = 0;
      pv[i] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]      = pv[i];
      req_op[4*i +: 4]  = pop[i];
      req_a[32*i +: 32] = pa[i];
      req_b[32*i +: 32] = pb[i];
    end
  endtask

  task automatic arm(input int r, input int op, input logic [31:0] a, input logic [31:0] b);
    pv[r] = 1; pop[r] = 4'(op); pa[r] = a; pb[r] = b;
  endtask

  // One clock: check ready, advance the model at the edge, check the response.
  task automatic cycle();
    int win, c;
    bit can;
    logic [NREQ-1:0] exp_rdy;
    drive();
    #1;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      c = (m_ptr + k) % NREQ;
      if (win < 0 && pv[c]) win = c;
    end
    can = !m_valid || rsp_ready;
    exp_rdy = '0;
    if (can && win >= 0) exp_rdy[win] = 1'b1;
    obs_ready = req_ready;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    if (can && win >= 0) begin
      m_valid = 1;
      m_id    = win;
      m_err   = (pop[win] > 4'd11);
      m_res   = ref_alu(int'(pop[win]), pa[win], pb[win]);
      m_ptr   = (win + 1) % NREQ;
      m_cnt[win] = m_cnt[win] + 16'd1;
      pv[win] = 0;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    if (m_valid) begin
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_result", 64'(rsp_result), 64'(m_res));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
    end
`ifdef ALU_ARB_PERF_EN
    for (int i = 0; i < NREQ; i++) chk("perf_cnt", 64'(perf_cnt[16*i +: 16]), 64'(m_cnt[i]));
`endif
  endtask

  task automatic op_check(input string tag, input int op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input bit exp_err);
    arm(0, op, a, b);
    cycle();
    chk(tag, 64'(rsp_result), 64'(exp_res));
    chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
  endtask

  initial begin
    logic [31:0] held_res;
    logic [1:0]  held_id;
    rst = 1'b1;
    rsp_ready = 1'b1;
`ifdef ALU_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    model_reset();
    for (int i = 0; i < NREQ; i++) begin pop[i] = 0; pa[i] = 0; pb[i] = 0; end
    drive();
    #3;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_result", 64'(rsp_result), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fairness: both requesters continuously valid.
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < NREQ; r++)
        if (!pv[r]) arm(r, 0, 32'(k), 32'(r));
      cycle();
      chk("fair_grant", 64'(obs_ready), 64'(2'b01 << (k % 2)));
      chk("fair_id", 64'(rsp_id), 64'(k % 2));
    end
    for (int r = 0; r < NREQ; r++) pv[r] = 0;
    cycle();

    // Single op on requester 0.
    arm(0, 0, 32'd5, 32'd7);
    cycle();
    chk("single_rdy", 64'(obs_ready), 64'd1);
    chk("single_id", 64'(rsp_id), 64'd0);
    chk("single_res", 64'(rsp_result), 64'd12);
    chk("single_err", 64'(rsp_err), 64'd0);

    // Backpressure with requester 1 waiting.
    held_res = rsp_result;
    held_id  = rsp_id;
    rsp_ready = 1'b0;
    arm(1, 5, 32'hF0F0_0000, 32'h0000_0F0F);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_rdy", 64'(obs_ready), 64'd0);
      chk("stall_res", 64'(rsp_result), 64'(held_res));
      chk("stall_id", 64'(rsp_id), 64'(held_id));
    end
    rsp_ready = 1'b1;
    cycle();
    chk("unstall_rdy", 64'(obs_ready), 64'd2);
    chk("unstall_res", 64'(rsp_result), 64'hF0F0_0F0F);

    op_check("sub",   1,  32'd3,         32'd5,         32'hFFFF_FFFE, 0);
    op_check("slt",   3,  32'hFFFF_FFFF, 32'd1,         32'd1,         0);
    op_check("sltu",  4,  32'hFFFF_FFFF, 32'd1,         32'd0,         0);
    op_check("eq",    10, 32'h1234_5678, 32'h1234_5678, 32'd1,         0);
    op_check("passb", 11, 32'd0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    op_check("sra",   7,  32'h8000_0000, 32'd4,         32'hF800_0000, 0);
    op_check("illeg", 13, 32'd9,         32'd9,         32'd0,         1);

    // Asynchronous reset while a response is pending.
    arm(1, 0, 32'd1, 32'd1);
    cycle();
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(rsp_valid), 64'd0);
    model_reset();
    drive();
    @(negedge clk);
    rst = 1'b0;
`ifdef ALU_ARB_PERF_EN
    for (int i = 0; i < NREQ; i++) chk("perf_rst", 64'(perf_cnt[16*i +: 16]), 64'd0);
`endif
    arm(1, 0, 32'd2, 32'd3);
    arm(0, 0, 32'd4, 32'd5);
    cycle();
    chk("post_rst_grant", 64'(obs_ready), 64'd1);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int r = 0; r < NREQ; r++) begin
        if (!pv[r] && $urandom_range(0, 3) != 0) begin
          logic [31:0] ra;
          ra = $urandom;
          arm(r, int'($urandom_range(0, 15)), ra,
              ($urandom_range(0, 7) == 0) ? ra : 32'($urandom));
        end
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
